// File: rtl/div_host_port.sv
// Host side of the divider's byte-serial link: shifts a dividend/divisor pair
// out as 8 push-strobed bytes, then gathers the 8 returned result bytes.
module div_host_port #(
  parameter int SETUP_CYC = 1,
  parameter int GAP_CYC   = 1,
  parameter int TIMEOUT   = 4096,
  parameter int TO_W      = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_sign,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  output logic [7:0]  div_data_out,
  output logic        div_push,
  output logic        div_sign,
  input  logic [7:0]  div_data_in,
  input  logic        div_pull,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_quot,
  output logic [31:0] res_rem,
  output logic        res_timeout,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PUSH, S_GAP, S_WAIT, S_COLLECT, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [15:0]      r_cyc;
  logic [2:0]       r_idx, r_cnt;
  logic [TO_W-1:0]  r_to;
  logic [63:0]      r_sh, r_res;
  logic             r_sign, r_to_flag;
  logic             w_setup_end, w_gap_end, w_to_hit, w_accept, w_drive;

  assign w_setup_end = (r_cyc == 16'(SETUP_CYC - 1));
  assign w_gap_end   = (r_cyc == 16'(GAP_CYC - 1));
  assign w_to_hit    = (r_to == TO_W'(TIMEOUT - 1));
  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_drive     = (r_state == S_SETUP) || (r_state == S_PUSH) || (r_state == S_GAP);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_SETUP;
      S_SETUP:   if (w_setup_end) w_next = S_PUSH;
      S_PUSH:    w_next = S_GAP;
      S_GAP:     if (w_gap_end) w_next = (r_idx == 3'd7) ? S_WAIT : S_SETUP;
      S_WAIT:    if (div_pull) w_next = S_COLLECT;
                 else if (w_to_hit) w_next = S_DONE;
      // a fresh pull restarts collection, so it outranks the final byte
      S_COLLECT: if (!div_pull && r_cnt == 3'd7) w_next = S_DONE;
      S_DONE:    if (res_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_to      <= '0;
      r_sh      <= '0;
      r_res     <= '0;
      r_sign    <= 1'b0;
      r_to_flag <= 1'b0;
    end else begin
      r_to  <= '0;
      r_cyc <= '0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_sh      <= {req_dividend, req_divisor};
          r_sign    <= req_sign;
          r_idx     <= '0;
          r_res     <= '0;
          r_to_flag <= 1'b0;
        end
        S_SETUP: r_cyc <= w_setup_end ? 16'd0 : r_cyc + 16'd1;
        S_GAP: begin
          r_cyc <= w_gap_end ? 16'd0 : r_cyc + 16'd1;
          if (w_gap_end && r_idx != 3'd7) begin
            r_idx <= r_idx + 3'd1;
            r_sh  <= {r_sh[55:0], 8'h00};
          end
        end
        S_WAIT: begin
          r_to <= r_to + TO_W'(1);
          if (div_pull) begin
            r_res <= {56'h0, div_data_in};
            r_cnt <= 3'd1;
          end else if (w_to_hit) begin
            r_res     <= '0;
            r_to_flag <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (div_pull) begin
            r_res <= {56'h0, div_data_in};
            r_cnt <= 3'd1;
          end else begin
            r_res[{r_cnt, 3'b000} +: 8] <= div_data_in;
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DONE: if (res_ready) begin
          r_sign    <= 1'b0;
          r_to_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign div_push     = (r_state == S_PUSH);
  assign div_data_out = w_drive ? r_sh[63:56] : 8'h00;
  assign div_sign     = r_sign;
  assign res_valid    = (r_state == S_DONE);
  assign res_quot     = res_valid ? r_res[63:32] : 32'h0;
  assign res_rem      = res_valid ? r_res[31:0]  : 32'h0;
  assign res_timeout  = res_valid && r_to_flag;

endmodule
